// File: rtl/nios2_qsys_nios2_cpu_debug_cmd_bridge.sv
// Debug command bridge: synchronises vJTAG update strobes, queues {ir,sr} commands in a FIFO and
// decodes each pop into one-hot action pulses. Optional parity check via NIOS2_DBG_CMD_PARITY_EN.
module nios2_qsys_nios2_cpu_debug_cmd_bridge #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = DATA_W - 3,
    localparam int NCMD       = 2 ** IR_W,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IR_W-1:0]     ir_in,
    input  logic [DATA_W-1:0]   sr,
    input  logic                vs_udr,
    input  logic                vs_uir,
    input  logic                cmd_ready,
    input  logic                clr_err,
`ifdef NIOS2_DBG_CMD_PARITY_EN
    input  logic                sr_par,
    output logic                parity_err,
`endif
    output logic                cmd_valid,
    output logic [IR_W-1:0]     cmd_ir,
    output logic [DATA_W-1:0]   jdo,
    output logic [NCMD-1:0]     take_action,
    output logic [NCMD-1:0]     take_no_action,
    output logic                ir_update,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers, arm window and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic                   udr_rise;

    assign armed = (arm_cnt == '0);

    // History keeps tracking the synced level while disarmed, so a strobe
    // that was already high when reset released is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_hist  <= 1'b0;
            uir_hist  <= 1'b0;
            arm_cnt   <= ARM_W'(SYNC_STAGES + 1);
            udr_rise  <= 1'b0;
            ir_update <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value, giving a true shift chain.
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist  <= udr_sync[SYNC_STAGES-1];
            uir_hist  <= uir_sync[SYNC_STAGES-1];
            if (!armed)
                arm_cnt <= arm_cnt - ARM_W'(1);
            udr_rise  <= armed & udr_sync[SYNC_STAGES-1] & ~udr_hist;
            ir_update <= armed & uir_sync[SYNC_STAGES-1] & ~uir_hist;
        end
    end

    // ------------------------------------------------------------------
    // Push / pop qualification
    // ------------------------------------------------------------------
    logic             full;
    logic             pop;
    logic             parity_ok;
    logic             push_ok;
    logic             overflow_set;
    logic             parity_set;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    cmd_t             mem [DEPTH];
    cmd_t             head;

    assign full      = (fifo_level == LVL_W'(DEPTH));
    assign cmd_valid = (fifo_level != '0);
    assign head      = mem[rd_ptr];
    assign cmd_ir    = cmd_valid ? head.ir : '0;

`ifdef NIOS2_DBG_CMD_PARITY_EN
    assign parity_ok = ~(^{ir_in, sr, sr_par});
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        pop          = 1'b0;
        push_ok      = 1'b0;
        overflow_set = 1'b0;
        parity_set   = 1'b0;
        if (cmd_valid && cmd_ready)
            pop = 1'b1;
        if (udr_rise) begin
            if (!parity_ok)
                parity_set = 1'b1;
            else if (!full || pop)
                push_ok = 1'b1;
            else
                overflow_set = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; pointers and level define validity, and reading is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= '{ir: ir_in, data: sr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop decode: jdo holds the last popped data, pulses last one cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo <= head.data;
                if (head.data[ACT_BIT])
                    take_action    <= NCMD'(1) << head.ir;
                else
                    take_no_action <= NCMD'(1) << head.ir;
            end
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else
            overflow <= overflow_set | (overflow & ~clr_err);
    end

`ifdef NIOS2_DBG_CMD_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= parity_set | (parity_err & ~clr_err);
    end
`else
    logic unused_parity;
    assign unused_parity = parity_set;
`endif

endmodule
